// File: rtl/weight_feeder_pkg.sv
// Shared definitions for the weight feeder and the per-PE weight buffers:
// FSM state encoding, default word/buffer sizes, and command validation.
package weight_feeder_pkg;

    // Defaults shared with the weight buffer so both sides agree on sizes.
    localparam int DATA_WIDTH_DEF   = 16;
    localparam int BUFFER_DEPTH_DEF = 16;
    localparam int NUM_BUF_DEF      = 4;
    localparam int ADDR_WIDTH_DEF   = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } feeder_state_t;

    // A command is usable only if every kernel fits in a buffer and
    // there is a target buffer for every kernel.
    function automatic logic cmd_valid(input logic [7:0] ksize,
                                       input logic [7:0] nker,
                                       input int         max_depth,
                                       input int         max_buf);
        return (ksize != 8'd0) && (int'(ksize) <= max_depth) &&
               (nker  != 8'd0) && (int'(nker)  <= max_buf);
    endfunction

endpackage

// File: rtl/weight_feeder.sv
// Weight feeder: streams num_kernels contiguous kernels from a
// synchronous-read weight memory into weight buffers 0..num_kernels-1.
// Each kernel is announced by a one-cycle flush pulse to its buffer,
// followed by kernel_size words on wdata, one per cycle.
module weight_feeder
    import weight_feeder_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int BUFFER_DEPTH = BUFFER_DEPTH_DEF,
    parameter int NUM_BUF      = NUM_BUF_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [7:0]            kernel_size,
    input  logic [7:0]            num_kernels,
    input  logic [NUM_BUF-1:0]    buf_busy,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [NUM_BUF-1:0]    flush,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int IDX_W = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;

    feeder_state_t         state_q;
    logic [7:0]            ksize_q;     // latched kernel_size
    logic [7:0]            nker_q;      // latched num_kernels
    logic [7:0]            kern_q;      // current kernel / target buffer j
    logic [7:0]            rd_cnt_q;    // reads issued for the current kernel
    logic [7:0]            wcnt_q;      // stream cycle index within the kernel
    logic [ADDR_WIDTH-1:0] addr_q;      // next read address (wraps naturally)
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NUM_BUF-1:0]    flush_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic [IDX_W-1:0]      buf_idx;
    logic [NUM_BUF-1:0]    flush_sel;
    logic                  rd_more;
    logic                  buf_free;

    assign buf_idx  = kern_q[IDX_W-1:0];
    assign addr_d   = addr_q + ADDR_WIDTH'(1);
    assign rd_more  = (rd_cnt_q < ksize_q);
    assign buf_free = ~buf_busy[buf_idx];

    // One-hot decode of the current target buffer.
    for (genvar gi = 0; gi < NUM_BUF; gi++) begin : g_flush_sel
        assign flush_sel[gi] = (buf_idx == IDX_W'(gi));
    end

    // Read enable depends on the live buf_busy input while waiting, so it
    // is decoded from registered state rather than registered itself.
    always_comb begin
        mem_en = 1'b0;
        case (state_q)
            ST_WAIT:              mem_en = buf_free;
            ST_FLUSH, ST_STREAM:  mem_en = rd_more;
            default:              mem_en = 1'b0;
        endcase
    end

    assign mem_addr = addr_q;
    assign flush    = flush_q;
    assign wdata    = wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

    // Command FSM with address/word/kernel counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ksize_q  <= 8'd0;
            nker_q   <= 8'd0;
            kern_q   <= 8'd0;
            rd_cnt_q <= 8'd0;
            wcnt_q   <= 8'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            flush_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ksize_q  <= kernel_size;
                        nker_q   <= num_kernels;
                        kern_q   <= 8'd0;
                        rd_cnt_q <= 8'd0;
                        wcnt_q   <= 8'd0;
                        addr_q   <= base_addr;
                        if (cmd_valid(kernel_size, num_kernels, BUFFER_DEPTH, NUM_BUF)) begin
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= ST_WAIT;
                        end else begin
                            // Rejected: report immediately, touch nothing.
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end

                ST_WAIT: begin
                    // Hold until the target buffer has finished its own flush.
                    if (buf_free) begin
                        addr_q   <= addr_d;
                        rd_cnt_q <= 8'd1;
                        flush_q  <= flush_sel;
                        state_q  <= ST_FLUSH;
                    end
                end

                ST_FLUSH: begin
                    flush_q <= '0;
                    wdata_q <= mem_rdata;   // word 0, presented next cycle
                    wcnt_q  <= 8'd0;
                    if (rd_more) begin
                        addr_q   <= addr_d;
                        rd_cnt_q <= rd_cnt_q + 8'd1;
                    end
                    state_q <= ST_STREAM;
                end

                ST_STREAM: begin
                    if (rd_more) begin
                        addr_q   <= addr_d;
                        rd_cnt_q <= rd_cnt_q + 8'd1;
                    end
                    // mem_rdata now holds word wcnt+1 of this kernel.
                    if ((wcnt_q + 8'd1) < ksize_q) begin
                        wdata_q <= mem_rdata;
                    end else begin
                        wdata_q <= '0;
                    end
                    if (wcnt_q == ksize_q - 8'd1) begin
                        if ((kern_q + 8'd1) < nker_q) begin
                            // Kernels are contiguous: addr_q keeps running.
                            kern_q  <= kern_q + 8'd1;
                            state_q <= ST_WAIT;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end else begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
                end

                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                    flush_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_feeder.sv
// Directed testbench for weight_feeder: a synchronous weight memory, a
// simple weight-buffer capture model and hand-computed expectations.
module tb_weight_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic [7:0]  kernel_size = '0;
    logic [7:0]  num_kernels = '0;
    logic [3:0]  buf_busy = '0;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic [3:0]  flush;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    weight_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .kernel_size (kernel_size),
        .num_kernels (num_kernels),
        .buf_busy    (buf_busy),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .flush       (flush),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Weight memory: mem[i] = 0xC000 | i, except three marker words.
    logic [15:0] mem [0:4095];
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    // Per-run logs
    int          en_cnt, flush_cnt, onehot_err, hold_viol, done_cyc;
    logic        err_at_done;
    int          en_cyc_a   [0:63];
    logic [11:0] en_addr_a  [0:63];
    int          flush_j_a  [0:15];
    int          flush_cyc_a[0:15];
    logic [15:0] wd_log     [0:63];
    logic        err_log    [0:63];
    logic [15:0] bufm       [0:3][0:15];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command (called #1 after a rising edge) and run it cycle by
    // cycle. Cycle 0 is the start cycle. Optional buf_busy window, mid-run
    // reset cycle, and a second start pulse.
    task automatic run_cmd(input logic [11:0] b, input logic [7:0] k, input logic [7:0] n,
                           input int bsy_from, input int bsy_len, input int bsy_bit,
                           input int rst_cyc, input int restart_cyc);
        int wr_ptr [0:3];
        int wr_rem [0:3];
        int c;
        bit fin;
        en_cnt = 0; flush_cnt = 0; onehot_err = 0; hold_viol = 0;
        done_cyc = -1; err_at_done = 1'bx;
        for (int i = 0; i < 64; i++) begin
            en_cyc_a[i] = -1; en_addr_a[i] = 12'hFFF; wd_log[i] = 16'hDEAD; err_log[i] = 1'bx;
        end
        for (int i = 0; i < 16; i++) begin
            flush_j_a[i] = -1; flush_cyc_a[i] = -1;
        end
        for (int j = 0; j < 4; j++) begin
            wr_ptr[j] = 0; wr_rem[j] = 0;
            for (int w = 0; w < 16; w++) bufm[j][w] = 16'hDEAD;
        end
        base_addr = b; kernel_size = k; num_kernels = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble config after acceptance; it must have no effect.
        base_addr = 12'h555; kernel_size = 8'd7; num_kernels = 8'd3;
        c = 1; fin = 0;
        while (!fin && c <= 200) begin
            buf_busy = (c >= bsy_from && c < bsy_from + bsy_len) ? (4'b0001 << bsy_bit) : 4'b0000;
            start    = (c == restart_cyc);
            rst      = (c == rst_cyc);
            @(negedge clk);
            if (c < 64) begin
                wd_log[c] = wdata; err_log[c] = err;
            end
            if (mem_en) begin
                if (en_cnt < 64) begin
                    en_cyc_a[en_cnt] = c; en_addr_a[en_cnt] = mem_addr;
                end
                en_cnt++;
            end
            if (buf_busy != 4'b0 && (mem_en || flush != 4'b0)) hold_viol++;
            for (int j = 0; j < 4; j++) begin
                if (wr_rem[j] > 0) begin
                    if (wr_ptr[j] < 16) bufm[j][wr_ptr[j]] = wdata;
                    wr_ptr[j]++; wr_rem[j]--;
                end
            end
            if (flush != 4'b0) begin
                if ($countones(flush) != 1) onehot_err++;
                for (int j = 0; j < 4; j++) begin
                    if (flush[j]) begin
                        if (flush_cnt < 16) begin
                            flush_j_a[flush_cnt] = j; flush_cyc_a[flush_cnt] = c;
                        end
                        wr_ptr[j] = 0; wr_rem[j] = int'(k);
                    end
                end
                flush_cnt++;
            end
            if (done) begin
                done_cyc = c; err_at_done = err; fin = 1;
            end
            if (c == rst_cyc) fin = 1;
            @(posedge clk); #1;
            c++;
        end
        buf_busy = 4'b0; start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'hC000 | 16'(i);
        mem[12'h010] = 16'hAAAA;
        mem[12'h011] = 16'hBBBB;
        mem[12'h012] = 16'hCCCC;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mem_en", {31'b0, mem_en}, 0);
        check("rst_addr",   {20'b0, mem_addr}, 0);
        check("rst_flush",  {28'b0, flush}, 0);
        check("rst_wdata",  {16'b0, wdata}, 0);
        check("rst_bdde",   {29'b0, busy, done, err}, 0);
        @(posedge clk); #1;

        // K=3, N=1, base 0x010
        run_cmd(12'h010, 8'd3, 8'd1, 0, 0, 0, 0, 0);
        check("t1_done_cyc", done_cyc, 6);
        check("t1_err",      {31'b0, err_at_done}, 0);
        check("t1_en_cnt",   en_cnt, 3);
        check("t1_en_first", en_cyc_a[0], 1);
        check("t1_en_last",  en_cyc_a[2], 3);
        check("t1_addr0",    {20'b0, en_addr_a[0]}, 32'h010);
        check("t1_addr1",    {20'b0, en_addr_a[1]}, 32'h011);
        check("t1_addr2",    {20'b0, en_addr_a[2]}, 32'h012);
        check("t1_flush_cnt", flush_cnt, 1);
        check("t1_flush_cyc", flush_cyc_a[0], 2);
        check("t1_flush_j",   flush_j_a[0], 0);
        check("t1_wd2",      {16'b0, wd_log[2]}, 0);
        check("t1_wd3",      {16'b0, wd_log[3]}, 32'hAAAA);
        check("t1_wd4",      {16'b0, wd_log[4]}, 32'hBBBB);
        check("t1_wd5",      {16'b0, wd_log[5]}, 32'hCCCC);
        check("t1_wd6",      {16'b0, wd_log[6]}, 0);
        check("t1_buf0_0",   {16'b0, bufm[0][0]}, 32'hAAAA);
        check("t1_buf0_1",   {16'b0, bufm[0][1]}, 32'hBBBB);
        check("t1_buf0_2",   {16'b0, bufm[0][2]}, 32'hCCCC);

        // K=2, N=4, base 0xFFE with address wrap
        run_cmd(12'hFFE, 8'd2, 8'd4, 0, 0, 0, 0, 0);
        check("t2_done_cyc", done_cyc, 17);
        check("t2_onehot",   onehot_err, 0);
        check("t2_flush_cnt", flush_cnt, 4);
        for (int j = 0; j < 4; j++) begin
            check("t2_flush_j",   flush_j_a[j], j);
            check("t2_flush_cyc", flush_cyc_a[j], 2 + 4 * j);
        end
        check("t2_en_cnt",   en_cnt, 8);
        check("t2_addr7",    {20'b0, en_addr_a[7]}, 32'h005);
        check("t2_b0w0", {16'b0, bufm[0][0]}, 32'hCFFE);
        check("t2_b0w1", {16'b0, bufm[0][1]}, 32'hCFFF);
        check("t2_b1w0", {16'b0, bufm[1][0]}, 32'hC000);
        check("t2_b1w1", {16'b0, bufm[1][1]}, 32'hC001);
        check("t2_b2w0", {16'b0, bufm[2][0]}, 32'hC002);
        check("t2_b2w1", {16'b0, bufm[2][1]}, 32'hC003);
        check("t2_b3w0", {16'b0, bufm[3][0]}, 32'hC004);
        check("t2_b3w1", {16'b0, bufm[3][1]}, 32'hC005);

        // K=2, N=2, buf_busy[1] high for cycles 5..9 while kernel 1 is due
        run_cmd(12'h100, 8'd2, 8'd2, 5, 5, 1, 0, 0);
        check("t3_done_cyc", done_cyc, 14);
        check("t3_hold_viol", hold_viol, 0);
        check("t3_en_cnt",   en_cnt, 4);
        check("t3_resume",   en_cyc_a[2], 10);
        check("t3_flush1",   flush_cyc_a[1], 11);
        check("t3_b1w0", {16'b0, bufm[1][0]}, 32'hC102);
        check("t3_b1w1", {16'b0, bufm[1][1]}, 32'hC103);

        // Rejected commands
        run_cmd(12'h040, 8'd0, 8'd1, 0, 0, 0, 0, 0);
        check("t4a_done_cyc", done_cyc, 1);
        check("t4a_err",      {31'b0, err_at_done}, 1);
        check("t4a_no_rd",    en_cnt + flush_cnt, 0);
        run_cmd(12'h040, 8'd17, 8'd1, 0, 0, 0, 0, 0);
        check("t4b_done_cyc", done_cyc, 1);
        check("t4b_err",      {31'b0, err_at_done}, 1);
        check("t4b_no_rd",    en_cnt + flush_cnt, 0);
        run_cmd(12'h040, 8'd2, 8'd5, 0, 0, 0, 0, 0);
        check("t4c_done_cyc", done_cyc, 1);
        check("t4c_err",      {31'b0, err_at_done}, 1);
        check("t4c_no_rd",    en_cnt + flush_cnt, 0);
        @(negedge clk);
        check("t4_err_sticky", {31'b0, err}, 1);
        @(posedge clk); #1;

        // K=1, N=1 clears err; second start at cycle 2 is ignored
        run_cmd(12'h020, 8'd1, 8'd1, 0, 0, 0, 0, 2);
        check("t5_err_clr",   {31'b0, err_log[1]}, 0);
        check("t5_done_cyc",  done_cyc, 4);
        check("t5_en_cnt",    en_cnt, 1);
        check("t5_flush_cyc", flush_cyc_a[0], 2);
        check("t5_wd3",       {16'b0, wd_log[3]}, 32'hC020);
        check("t5_wd4",       {16'b0, wd_log[4]}, 0);
        repeat (2) begin
            @(negedge clk);
            check("t5_idle_busy", {30'b0, busy, mem_en}, 0);
            @(posedge clk); #1;
        end

        // K=4 reset at 2nd stream cycle (cycle 4)
        run_cmd(12'h030, 8'd4, 8'd1, 0, 0, 0, 4, 0);
        check("t6_flush_cyc", flush_cyc_a[0], 2);
        rst = 1'b0;
        @(negedge clk);
        check("t6_mem_en", {31'b0, mem_en}, 0);
        check("t6_flush",  {28'b0, flush}, 0);
        check("t6_wdata",  {16'b0, wdata}, 0);
        check("t6_bdde",   {29'b0, busy, done, err}, 0);
        check("t6_addr",   {20'b0, mem_addr}, 0);
        @(posedge clk); #1;
        run_cmd(12'h010, 8'd3, 8'd1, 0, 0, 0, 0, 0);
        check("t6_done_cyc", done_cyc, 6);
        check("t6_b0w0", {16'b0, bufm[0][0]}, 32'hAAAA);
        check("t6_b0w1", {16'b0, bufm[0][1]}, 32'hBBBB);
        check("t6_b0w2", {16'b0, bufm[0][2]}, 32'hCCCC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/weight_feeder.md
Name: weight_feeder

Overview:
- Write-side master for the per-PE weight buffers. It streams weight kernels into them.
- On one start command it reads num_kernels contiguous kernels of kernel_size words each from a synchronous-read weight memory.
- Kernel j goes to weight buffer j: a one-cycle flush pulse, then kernel_size consecutive data words, one per cycle, aligned to the buffer's write window.
- Sits between the weight BRAM / DMA landing area and the PE array's weight buffers.

Parameters:
- DATA_WIDTH, 16, weight word width (matches buffer data_in).
- BUFFER_DEPTH, 16, capacity of each weight buffer in words; maximum legal kernel_size.
- NUM_BUF, 4, number of target weight buffers (one flush line each).
- ADDR_WIDTH, 12, weight memory word-address width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  memory address of word 0 of kernel 0; latched on start.
- kernel_size  in  8  words per kernel; latched on start.
- num_kernels  in  8  kernels to load (buffers 0..num_kernels-1); latched on start.
- buf_busy  in  NUM_BUF  per-buffer flush-busy status from the weight buffers.
- mem_en  out  1  memory read enable.
- mem_addr  out  ADDR_WIDTH  memory read address.
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_en.
- flush  out  NUM_BUF  one-hot, one-cycle write-start pulse to buffer j.
- wdata  out  DATA_WIDTH  broadcast weight word to all buffers' data_in.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  set with done when the command was rejected; cleared on next accepted start.

Behaviour:
- Reset: state IDLE; counters 0; mem_en, mem_addr, flush, wdata, busy, done, err all 0.
- Reset mid-operation returns to IDLE next cycle with no further flush or memory reads. A buffer already in its write window then captures wdata=0 for its remaining words.
- States: IDLE, WAIT, FLUSH, STREAM, DONE.
- IDLE:
  - On start, latch config and validate.
  - Command is invalid if kernel_size==0, kernel_size>BUFFER_DEPTH, num_kernels==0 or num_kernels>NUM_BUF. Invalid -> DONE with err; no memory reads, no flush.
  - Valid -> WAIT with j=0, addr=base_addr, err cleared.
- WAIT: if buf_busy[j]==0, assert mem_en, issue addr, addr+1, and go to FLUSH. Otherwise hold.
- FLUSH (cycle T):
  - flush[j]=1 for this cycle only.
  - If kernel_size>1, issue the next address.
  - Capture mem_rdata (word 0) into wdata.
  - Go to STREAM.
- STREAM (cycles T+1..T+kernel_size):
  - wdata presents word k at T+1+k. This matches the buffer, which writes data_in during the kernel_size cycles after the flush pulse.
  - Address issue continues until kernel_size reads for kernel j have been issued in total (first one in WAIT).
  - Capture continues until word kernel_size-1 is registered.
  - On the last stream cycle: if j+1<num_kernels, j++ and go to WAIT (addr keeps running: kernels are contiguous); else go to DONE.
- DONE: done=1 for one cycle, busy=0 in this cycle, then IDLE.
- wdata is 0 whenever no word is being presented.
- Address arithmetic: mem_addr wraps modulo 2^ADDR_WIDTH; no error on wrap.
- start while not IDLE is ignored. Config inputs changing after acceptance have no effect.
- kernel_size==1: WAIT issues the only read, FLUSH issues none, STREAM is one cycle.
- Cycle budget, valid command with buffers idle: done asserts exactly num_kernels*(kernel_size+2)+1 cycles after the start cycle.

Decomposition:
- Shared package: state encoding localparams, the BUFFER_DEPTH/DATA_WIDTH defaults used by both this block and the weight buffer, and the validation limits.
- No sub-module: one FSM plus address, word and kernel counters in a single module.

Test Plan:
- K=3, N=1, base=0x010, mem[0x10..0x12]=A,B,C: mem_en at cycles 1-3 with addr 0x10-0x12; flush[0] at cycle 2; wdata=A,B,C at cycles 3,4,5; done at cycle 6. A weight buffer model holds A,B,C.
- K=2, N=4, base=0xFFE (wraps): buffer j holds words from addresses (0xFFE+2j) mod 4096. flush is one-hot, j=0..3 in order; done at cycle 17.
- buf_busy[1] forced high for 5 cycles when kernel 1 is due: FSM holds in WAIT with mem_en=0 and flush=0, then resumes. The cycle count grows by exactly 5.
- kernel_size=0, kernel_size=17 and num_kernels=5, each alone: done+err one cycle after start; mem_en and flush never assert. A following valid start clears err.
- K=1, N=1: single read, flush, one wdata cycle, done at cycle 4. A second start pulsed during busy is ignored.
- rst asserted at the 2nd STREAM cycle of K=4: next cycle all outputs 0 and state IDLE. A fresh start then completes normally.
